// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame controller: state encodings,
// error codes, default sync marker and header field positions.
package uart_pkg;

   localparam logic [3:0] ST_WAIT_SYNC = 4'b0001;
   localparam logic [3:0] ST_GET_HDR   = 4'b0010;
   localparam logic [3:0] ST_GET_DATA  = 4'b0100;
   localparam logic [3:0] ST_GET_CHK   = 4'b1000;

   typedef enum logic [3:0] {
      WAIT_SYNC = ST_WAIT_SYNC,
      GET_HDR   = ST_GET_HDR,
      GET_DATA  = ST_GET_DATA,
      GET_CHK   = ST_GET_CHK
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CHK     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // The write flag sits this many bits below the header byte width (i.e. the MSB).
   localparam int HDR_WR_BIT_OFS = 1;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: counts ticks while enabled and flags the tick
// that lands on the final count, both combinationally and registered.
module uart_timeout_cnt #(
   parameter int TIMEOUT_TICKS = 2048
) (
   input  logic clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_tick,
   output logic o_expire,
   output logic o_expiring
);

   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_TICKS - 1);

   logic [15:0] r_count;
   logic        r_expire;
   logic        w_expiring;

   // A clear in the same cycle as the final tick suppresses the expiry.
   assign w_expiring = i_enable & i_tick & ~i_clear & (r_count == LAST_COUNT);
   assign o_expiring = w_expiring;
   assign o_expire   = r_expire;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_count  <= 16'd0;
         r_expire <= 1'b0;
      end else begin
         r_expire <= w_expiring;
         if (i_clear) begin
            r_count <= 16'd0;
         end else if (i_enable && i_tick) begin
            r_count <= w_expiring ? 16'd0 : r_count + 16'd1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Turns the UART receiver's byte stream (SYNC, HDR, DATA, CHK frames) into
// single-cycle register write/read strobes, with checksum and timeout errors.
module uart_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int                 NB_DATA       = 8,
   parameter int                 NB_ADDR       = 4,
   parameter logic [NB_DATA-1:0] SYNC_BYTE     = NB_DATA'(DEFAULT_SYNC_BYTE),
   parameter int                 TIMEOUT_TICKS = 2048
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   output logic               o_wr_en,
   output logic               o_rd_en,
   output logic [NB_ADDR-1:0] o_addr,
   output logic [NB_DATA-1:0] o_wdata,
   output logic               o_err,
   output logic [1:0]         o_err_code,
   output logic               o_busy,
   output logic [7:0]         o_frame_cnt
);

   localparam int WR_BIT = NB_DATA - HDR_WR_BIT_OFS;

   state_t             r_state;
   state_t             w_stateNext;
   logic [NB_DATA-1:0] r_hdr;
   logic [NB_DATA-1:0] r_data;
   logic               r_wrEn;
   logic               r_rdEn;
   logic               r_chkErr;
   logic [NB_ADDR-1:0] r_addr;
   logic [NB_DATA-1:0] r_wdata;
   logic [1:0]         r_errCode;
   logic [7:0]         r_frameCnt;
   logic               w_frameEnd;
   logic               w_chkOk;
   logic               w_expire;
   logic               w_expiring;
   logic               w_idle;

   assign w_idle = (r_state == WAIT_SYNC);

   uart_timeout_cnt #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) u_timeout (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_clear    (i_rx_done | w_idle),
      .i_enable   (~w_idle),
      .i_tick     (i_tick),
      .o_expire   (w_expire),
      .o_expiring (w_expiring)
   );

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state <= WAIT_SYNC;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A received byte always takes priority over a timeout in the same cycle.
   always_comb begin
      w_stateNext = r_state;
      w_frameEnd  = 1'b0;
      w_chkOk     = 1'b0;
      unique case (r_state)
         WAIT_SYNC: begin
            if (i_rx_done && (i_rx_data == SYNC_BYTE)) w_stateNext = GET_HDR;
         end
         GET_HDR: begin
            if (i_rx_done)       w_stateNext = GET_DATA;
            else if (w_expiring) w_stateNext = WAIT_SYNC;
         end
         GET_DATA: begin
            if (i_rx_done)       w_stateNext = GET_CHK;
            else if (w_expiring) w_stateNext = WAIT_SYNC;
         end
         GET_CHK: begin
            if (i_rx_done) begin
               w_stateNext = WAIT_SYNC;
               w_frameEnd  = 1'b1;
               w_chkOk     = (i_rx_data == (r_hdr ^ r_data));
            end else if (w_expiring) begin
               w_stateNext = WAIT_SYNC;
            end
         end
         default: w_stateNext = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_hdr  <= '0;
         r_data <= '0;
      end else if (i_rx_done) begin
         if (r_state == GET_HDR)  r_hdr  <= i_rx_data;
         if (r_state == GET_DATA) r_data <= i_rx_data;
      end
   end

   // Timeout strobes come from the counter's own register; checksum ones from here.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_wrEn     <= 1'b0;
         r_rdEn     <= 1'b0;
         r_chkErr   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_errCode  <= ERR_NONE;
         r_frameCnt <= 8'd0;
      end else begin
         r_wrEn   <= 1'b0;
         r_rdEn   <= 1'b0;
         r_chkErr <= 1'b0;
         if (w_frameEnd) begin
            if (w_chkOk) begin
               r_addr     <= r_hdr[NB_ADDR-1:0];
               r_frameCnt <= r_frameCnt + 8'd1;
               if (r_hdr[WR_BIT]) begin
                  r_wrEn  <= 1'b1;
                  r_wdata <= r_data;
               end else begin
                  r_rdEn  <= 1'b1;
               end
            end else begin
               r_chkErr  <= 1'b1;
               r_errCode <= ERR_CHK;
            end
         end else if (w_expiring) begin
            r_errCode <= ERR_TIMEOUT;
         end
      end
   end

   assign o_wr_en     = r_wrEn;
   assign o_rd_en     = r_rdEn;
   assign o_err       = r_chkErr | w_expire;
   assign o_addr      = r_addr;
   assign o_wdata     = r_wdata;
   assign o_err_code  = r_errCode;
   assign o_frame_cnt = r_frameCnt;
   assign o_busy      = ~w_idle;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus random frames,
// compared every cycle against a frame-queue reference model.
module tb_uart_cmd_ctrl;

   localparam int         TIMEOUT = 2048;
   localparam logic [7:0] SYNC    = 8'hA5;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_tick;
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic       o_wr_en;
   logic       o_rd_en;
   logic [3:0] o_addr;
   logic [7:0] o_wdata;
   logic       o_err;
   logic [1:0] o_err_code;
   logic       o_busy;
   logic [7:0] o_frame_cnt;

   int cmpCount  = 0;
   int failCount = 0;

   // Reference model: bytes of the frame in progress plus expected outputs.
   logic [7:0] frame[$];
   int         tickRun;
   logic       mWr, mRd, mErr;
   logic [3:0] mAddr;
   logic [7:0] mWdata;
   logic [1:0] mCode;
   logic [7:0] mCnt;

   uart_cmd_ctrl #(
      .NB_DATA       (8),
      .NB_ADDR       (4),
      .SYNC_BYTE     (SYNC),
      .TIMEOUT_TICKS (TIMEOUT)
   ) dut (
      .clk         (clk),
      .i_reset     (i_reset),
      .i_tick      (i_tick),
      .i_rx_data   (i_rx_data),
      .i_rx_done   (i_rx_done),
      .o_wr_en     (o_wr_en),
      .o_rd_en     (o_rd_en),
      .o_addr      (o_addr),
      .o_wdata     (o_wdata),
      .o_err       (o_err),
      .o_err_code  (o_err_code),
      .o_busy      (o_busy),
      .o_frame_cnt (o_frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      cmpCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string step);
      checkOutput({step, " wr/rd/err"}, {29'd0, o_wr_en, o_rd_en, o_err}, {29'd0, mWr, mRd, mErr});
      checkOutput({step, " busy"},      {31'd0, o_busy},      {31'd0, (frame.size() != 0)});
      checkOutput({step, " addr"},      {28'd0, o_addr},      {28'd0, mAddr});
      checkOutput({step, " wdata"},     {24'd0, o_wdata},     {24'd0, mWdata});
      checkOutput({step, " err_code"},  {30'd0, o_err_code},  {30'd0, mCode});
      checkOutput({step, " frame_cnt"}, {24'd0, o_frame_cnt}, {24'd0, mCnt});
   endtask

   task automatic modelReset();
      frame.delete();
      tickRun = 0;
      {mWr, mRd, mErr} = 3'b000;
      mAddr  = 4'd0;
      mWdata = 8'd0;
      mCode  = 2'd0;
      mCnt   = 8'd0;
   endtask

   task automatic modelCycle(input bit rxDone, input logic [7:0] d, input bit tick);
      logic [7:0] hdr, dat;
      {mWr, mRd, mErr} = 3'b000;
      if (rxDone) begin
         tickRun = 0;
         if (frame.size() == 0) begin
            if (d == SYNC) frame.push_back(d);
         end else begin
            frame.push_back(d);
            if (frame.size() == 4) begin
               hdr = frame[1];
               dat = frame[2];
               if (d == (hdr ^ dat)) begin
                  mAddr = hdr[3:0];
                  mCnt  = mCnt + 8'd1;
                  if (hdr[7]) begin
                     mWr    = 1'b1;
                     mWdata = dat;
                  end else begin
                     mRd = 1'b1;
                  end
               end else begin
                  mErr  = 1'b1;
                  mCode = 2'b01;
               end
               frame.delete();
            end
         end
      end else if (frame.size() != 0 && tick) begin
         tickRun++;
         if (tickRun == TIMEOUT) begin
            mErr  = 1'b1;
            mCode = 2'b10;
            frame.delete();
            tickRun = 0;
         end
      end
   endtask

   // Entered just after a falling edge; checks outputs one cycle later.
   task automatic driveCycle(input string step, input bit rxDone, input logic [7:0] d, input bit tick);
      i_rx_done = rxDone;
      i_rx_data = d;
      i_tick    = tick;
      @(negedge clk);
      modelCycle(rxDone, d, tick);
      checkAll(step);
   endtask

   task automatic applyStimulus(input string step, input logic [7:0] b, input int idle,
                                input bit idleTick, input bit byteTick);
      for (int i = 0; i < idle; i++) driveCycle({step, " idle"}, 1'b0, 8'($urandom), idleTick);
      driveCycle(step, 1'b1, b, byteTick);
   endtask

   task automatic sendFrame(input string step, input logic [7:0] h, input logic [7:0] d, input logic [7:0] c);
      applyStimulus(step, SYNC, 0, 1'b0, 1'b0);
      applyStimulus(step, h, 0, 1'b0, 1'b0);
      applyStimulus(step, d, 0, 1'b0, 1'b0);
      applyStimulus(step, c, 0, 1'b0, 1'b0);
   endtask

   task automatic doReset(input string step);
      i_reset   = 1'b1;
      i_rx_done = 1'b0;
      i_tick    = 1'b0;
      @(negedge clk);
      modelReset();
      checkAll(step);
      i_reset = 1'b0;
   endtask

   initial begin
      logic [7:0] h, d, c, junk;
      i_reset   = 1'b1;
      i_tick    = 1'b0;
      i_rx_data = 8'd0;
      i_rx_done = 1'b0;
      modelReset();
      @(negedge clk);
      doReset("reset");

      sendFrame("write", 8'h83, 8'h3C, 8'hBF);
      driveCycle("write after", 1'b0, 8'h00, 1'b0);
      sendFrame("read", 8'h05, 8'h00, 8'h05);
      sendFrame("badchk", 8'h83, 8'h3C, 8'h00);

      applyStimulus("timeout", SYNC, 1, 1'b1, 1'b0);
      applyStimulus("timeout", 8'h83, 0, 1'b0, 1'b1);
      for (int i = 0; i < TIMEOUT; i++) driveCycle("timeout wait", 1'b0, 8'h00, 1'b1);
      driveCycle("timeout after", 1'b0, 8'h00, 1'b1);
      sendFrame("post-timeout", 8'h8A, 8'h77, 8'hFD);

      applyStimulus("synchunt", 8'h11, 2, 1'b1, 1'b0);
      applyStimulus("synchunt", 8'h22, 0, 1'b0, 1'b1);
      applyStimulus("synchunt", SYNC, 0, 1'b0, 1'b0);
      applyStimulus("synchunt", 8'h81, 0, 1'b0, 1'b0);
      applyStimulus("synchunt", 8'h55, TIMEOUT - 1, 1'b1, 1'b1);
      applyStimulus("synchunt", 8'hD4, 0, 1'b0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         h    = 8'($urandom);
         d    = 8'($urandom);
         c    = ($urandom_range(0, 3) == 0) ? (h ^ d ^ 8'(1 << $urandom_range(0, 7))) : (h ^ d);
         junk = 8'($urandom);
         if (junk == SYNC) junk = 8'h00;
         if ($urandom_range(0, 2) == 0) applyStimulus("rand junk", junk, $urandom_range(0, 2), 1'($urandom), 1'($urandom));
         applyStimulus("rand sync", SYNC, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         applyStimulus("rand hdr",  h,    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         applyStimulus("rand data", d,    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         applyStimulus("rand chk",  c,    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      end

      applyStimulus("midreset", SYNC, 0, 1'b0, 1'b0);
      applyStimulus("midreset", 8'h82, 0, 1'b0, 1'b0);
      doReset("midreset reset");
      sendFrame("after reset", 8'h82, 8'h10, 8'h92);
      driveCycle("final", 1'b0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
